// File: rtl/conv_pkg.sv
// Shared conv definitions: FSM encoding, tile defaults and the latched row-fetch configuration.
package conv_pkg;

  localparam int unsigned BuffersNumDefault  = 3;
  localparam int unsigned PixelsInRowDefault = 32;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } conv_rows_state_e;

  typedef struct packed {
    logic [3:0]  k;
    logic [3:0]  s;
    logic [3:0]  p;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [15:0] ox_start;
    logic [15:0] oy_start;
    logic [15:0] poy;
    logic [15:0] if_idx;
  } conv_rows_cfg_t;

endpackage

// File: rtl/conv_rows_addr_calc.sv
// Combinational row/column address generation for one kernel offset (ky, kx).
module conv_rows_addr_calc
  import conv_pkg::*;
#(
  parameter int unsigned BUFFERS_NUM = BuffersNumDefault
) (
  input  logic [3:0]                 s,
  input  logic [3:0]                 p,
  input  logic [3:0]                 ky,
  input  logic [3:0]                 kx,
  input  logic [15:0]                iy,
  input  logic [15:0]                ox_start,
  input  logic [15:0]                oy_start,
  input  logic [15:0]                poy,
  output logic [16*BUFFERS_NUM-1:0]  row,
  output logic [BUFFERS_NUM-1:0]     row_mask,
  output logic [15:0]                x_start,
  output logic [3:0]                 x_pad
);

  logic signed [17:0] s_e, p_e, ky_e, kx_e, iy_e, ox_e, oy_e;
  logic signed [17:0] r, c;

  assign s_e  = {14'd0, s};
  assign p_e  = {14'd0, p};
  assign ky_e = {14'd0, ky};
  assign kx_e = {14'd0, kx};
  assign iy_e = {2'd0, iy};
  assign ox_e = {2'd0, ox_start};
  assign oy_e = {2'd0, oy_start};

  always_comb begin
    row      = '0;
    row_mask = '0;
    r        = '0;
    for (int b = 0; b < BUFFERS_NUM; b++) begin
      r = (oy_e + 18'(b) - 18'sd1) * s_e + ky_e - p_e + 18'sd1;
      if ((32'(b) < 32'(poy)) && (r >= 18'sd1) && (r <= iy_e)) begin
        row_mask[b]     = 1'b1;
        row[16*b +: 16] = r[15:0];
      end
    end
  end

  // Columns left of the map are padding; fetch starts at column 1.
  always_comb begin
    c = (ox_e - 18'sd1) * s_e + kx_e - p_e + 18'sd1;
    if (c < 18'sd1) begin
      x_start = 16'd1;
      x_pad   = 4'(18'sd1 - c);
    end else begin
      x_start = c[15:0];
      x_pad   = 4'd0;
    end
  end

endmodule

// File: rtl/conv_rows_ctrl.sv
// Walks the k*k kernel offsets of one tile-channel and emits one row-fetch descriptor per beat.
module conv_rows_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned BUFFERS_NUM   = BuffersNumDefault,
  parameter int unsigned PIXELS_IN_ROW = PixelsInRowDefault
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [3:0]                 k,
  input  logic [3:0]                 s,
  input  logic [3:0]                 p,
  input  logic [15:0]                ix,
  input  logic [15:0]                iy,
  input  logic [15:0]                ox_start,
  input  logic [15:0]                oy_start,
  input  logic [15:0]                pox,
  input  logic [15:0]                poy,
  input  logic [15:0]                if_idx,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [16*BUFFERS_NUM-1:0]  out_row,
  output logic [BUFFERS_NUM-1:0]     out_row_mask,
  output logic [15:0]                out_x_start,
  output logic [3:0]                 out_x_pad,
  output logic [3:0]                 out_ky,
  output logic [3:0]                 out_kx,
  output logic [15:0]                out_if,
  output logic                       conv_rows_add_end1
);

  conv_rows_state_e state_q;
  conv_rows_cfg_t   cfg_q, cfg_in, cfg_n;
  logic [3:0]       ky_q, kx_q, ky_n, kx_n;
  logic             load, hs, last, upd;

  logic [16*BUFFERS_NUM-1:0] row_c;
  logic [BUFFERS_NUM-1:0]    mask_c;
  logic [15:0]               x_start_c;
  logic [3:0]                x_pad_c;

  always_comb begin
    cfg_in.k        = (k == 4'd0) ? 4'd1 : k;
    cfg_in.s        = (s == 4'd0) ? 4'd1 : s;
    cfg_in.p        = p;
    cfg_in.ix       = ix;
    cfg_in.iy       = iy;
    cfg_in.ox_start = ox_start;
    cfg_in.oy_start = oy_start;
    cfg_in.poy      = poy;
    cfg_in.if_idx   = if_idx;

    load  = (state_q == StIdle) && en;
    hs    = out_valid && out_ready;
    last  = (ky_q == cfg_q.k - 4'd1) && (kx_q == cfg_q.k - 4'd1);
    upd   = load || (hs && !last);
    cfg_n = load ? cfg_in : cfg_q;

    ky_n = ky_q;
    kx_n = kx_q;
    if (load) begin
      ky_n = 4'd0;
      kx_n = 4'd0;
    end else if (kx_q == cfg_q.k - 4'd1) begin
      kx_n = 4'd0;
      ky_n = ky_q + 4'd1;
    end else begin
      kx_n = kx_q + 4'd1;
    end
  end

  // Outputs are registered, so the next beat's addresses are computed one cycle ahead.
  conv_rows_addr_calc #(
    .BUFFERS_NUM(BUFFERS_NUM)
  ) u_addr_calc (
    .s        (cfg_n.s),
    .p        (cfg_n.p),
    .ky       (ky_n),
    .kx       (kx_n),
    .iy       (cfg_n.iy),
    .ox_start (cfg_n.ox_start),
    .oy_start (cfg_n.oy_start),
    .poy      (cfg_n.poy),
    .row      (row_c),
    .row_mask (mask_c),
    .x_start  (x_start_c),
    .x_pad    (x_pad_c)
  );

  assign conv_rows_add_end1 = hs && last && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      out_valid    <= 1'b0;
      cfg_q        <= '0;
      ky_q         <= 4'd0;
      kx_q         <= 4'd0;
      out_row      <= '0;
      out_row_mask <= '0;
      out_x_start  <= 16'd0;
      out_x_pad    <= 4'd0;
      out_ky       <= 4'd0;
      out_kx       <= 4'd0;
      out_if       <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_q   <= StRun;
            out_valid <= 1'b1;
            cfg_q     <= cfg_in;
            ky_q      <= 4'd0;
            kx_q      <= 4'd0;
          end
        end
        StRun: begin
          if (out_ready) begin
            if (last) begin
              state_q   <= StIdle;
              out_valid <= 1'b0;
              ky_q      <= 4'd0;
              kx_q      <= 4'd0;
            end else begin
              ky_q <= ky_n;
              kx_q <= kx_n;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (upd) begin
        out_row      <= row_c;
        out_row_mask <= mask_c;
        out_x_start  <= x_start_c;
        out_x_pad    <= x_pad_c;
        out_ky       <= ky_n;
        out_kx       <= kx_n;
        out_if       <= cfg_n.if_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && load) begin
      assert (poy <= 16'(BUFFERS_NUM));
      assert (pox <= 16'(PIXELS_IN_ROW));
    end
    if (!reset && out_valid) begin
      assert (cfg_q.ix != 16'd0);
    end
  end

endmodule

// File: tb/tb_conv_rows_ctrl.sv
// Directed bench for conv_rows_ctrl: hand-checked beats plus a small reference address model.
module tb_conv_rows_ctrl;

  localparam int unsigned B = 3;

  logic          clk = 1'b0;
  logic          reset, en, out_ready;
  logic [3:0]    k, s, p;
  logic [15:0]   ix, iy, ox_start, oy_start, pox, poy, if_idx;
  logic          out_valid, conv_rows_add_end1;
  logic [16*B-1:0] out_row;
  logic [B-1:0]  out_row_mask;
  logic [15:0]   out_x_start, out_if;
  logic [3:0]    out_x_pad, out_ky, out_kx;

  int vectors = 0;
  int miscompares = 0;
  int m_k, m_s, m_p, m_ox, m_oy, m_poy, m_iy, m_if;

  conv_rows_ctrl #(.BUFFERS_NUM(B), .PIXELS_IN_ROW(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .en                 (en),
    .k                  (k),
    .s                  (s),
    .p                  (p),
    .ix                 (ix),
    .iy                 (iy),
    .ox_start           (ox_start),
    .oy_start           (oy_start),
    .pox                (pox),
    .poy                (poy),
    .if_idx             (if_idx),
    .out_ready          (out_ready),
    .out_valid          (out_valid),
    .out_row            (out_row),
    .out_row_mask       (out_row_mask),
    .out_x_start        (out_x_start),
    .out_x_pad          (out_x_pad),
    .out_ky             (out_ky),
    .out_kx             (out_kx),
    .out_if             (out_if),
    .conv_rows_add_end1 (conv_rows_add_end1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_beat(input int ky, input int kx, input bit last);
    logic [16*B-1:0] er;
    logic [B-1:0]    em;
    int r, c, xs, pad;
    er = '0;
    em = '0;
    for (int b = 0; b < int'(B); b++) begin
      r = (m_oy + b - 1) * m_s + ky - m_p + 1;
      if (b < m_poy && r >= 1 && r <= m_iy) begin
        em[b] = 1'b1;
        er[16*b +: 16] = 16'(r);
      end
    end
    c   = (m_ox - 1) * m_s + kx - m_p + 1;
    xs  = (c < 1) ? 1 : c;
    pad = (c < 1) ? 1 - c : 0;
    chk("valid", out_valid, 1);
    chk("ky", out_ky, ky);
    chk("kx", out_kx, kx);
    chk("row", out_row, er);
    chk("mask", out_row_mask, em);
    chk("x_start", out_x_start, xs);
    chk("x_pad", out_x_pad, pad);
    chk("if", out_if, m_if);
    chk("end1", conv_rows_add_end1, last && out_ready);
  endtask

  task automatic start(input int kk, input int ss, input int pp, input int ox, input int oy,
                       input int py, input int iyy, input int ifx);
    k = 4'(kk); s = 4'(ss); p = 4'(pp);
    ox_start = 16'(ox); oy_start = 16'(oy); poy = 16'(py); iy = 16'(iyy); if_idx = 16'(ifx);
    m_k = (kk == 0) ? 1 : kk;
    m_s = (ss == 0) ? 1 : ss;
    m_p = pp; m_ox = ox; m_oy = oy; m_poy = py; m_iy = iyy; m_if = ifx;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Upstream inputs are scrambled during a stall; the latched beat must not move.
  task automatic run_beats(input int stall_at, input int stall_len);
    int n;
    n = 0;
    for (int ky = 0; ky < m_k; ky++) begin
      for (int kx = 0; kx < m_k; kx++) begin
        if (n == stall_at) begin
          out_ready = 1'b0;
          oy_start = 16'd9; ox_start = 16'd9; k = 4'd7; iy = 16'd2;
          for (int i = 0; i < stall_len; i++) begin
            #1; check_beat(ky, kx, 1'b0);
            @(posedge clk); #1;
          end
          out_ready = 1'b1;
        end
        #1; check_beat(ky, kx, n == m_k * m_k - 1);
        @(posedge clk); #1;
        n++;
      end
    end
    chk("idle_after_run", out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; out_ready = 1'b1;
    k = '0; s = '0; p = '0; ix = 16'd64; iy = '0; ox_start = '0; oy_start = '0;
    pox = 16'd32; poy = '0; if_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_row", out_row, 0);
    chk("rst_mask", out_row_mask, 0);
    chk("rst_xstart", out_x_start, 0);
    chk("rst_end1", conv_rows_add_end1, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);

    // 3x3, pad 1, top-left tile
    start(3, 1, 1, 1, 1, 3, 8, 5);
    chk("a_row0", out_row, {16'd2, 16'd1, 16'd0});
    chk("a_mask0", out_row_mask, 3'b110);
    chk("a_xs0", out_x_start, 16'd1);
    chk("a_pad0", out_x_pad, 4'd1);
    run_beats(-1, 0);

    // Back-to-back restart after the single IDLE cycle: 1x1, stride 2
    start(1, 2, 0, 3, 4, 3, 10, 2);
    chk("b_row0", out_row, {16'd0, 16'd9, 16'd7});
    chk("b_mask0", out_row_mask, 3'b011);
    chk("b_xs0", out_x_start, 16'd5);
    run_beats(-1, 0);

    start(3, 1, 1, 1, 1, 3, 8, 6);
    run_beats(4, 5);

    // poy=2 with every row in range
    start(2, 1, 0, 2, 2, 2, 20, 1);
    run_beats(-1, 0);

    // k=0 and s=0 behave as 1
    start(0, 0, 0, 3, 2, 1, 5, 7);
    chk("e_row0", out_row, {16'd0, 16'd0, 16'd2});
    chk("e_mask0", out_row_mask, 3'b001);
    chk("e_xs0", out_x_start, 16'd3);
    run_beats(-1, 0);

    // Reset on the 4th handshake
    start(3, 1, 1, 1, 1, 3, 8, 3);
    for (int n = 0; n < 3; n++) begin
      #1; check_beat(n / 3, n % 3, 1'b0);
      @(posedge clk); #1;
    end
    #1; check_beat(1, 0, 1'b0);
    reset = 1'b1;
    #1; chk("rst_hs_end1", conv_rows_add_end1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_hs_valid", out_valid, 0);
    chk("rst_hs_row", out_row, 0);
    #1; chk("rst_hs_end1_after", conv_rows_add_end1, 0);
    start(3, 1, 1, 1, 1, 3, 8, 3);
    run_beats(-1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
